// File: rtl/uart_rx.sv
// UART receiver: two-flop synchroniser, mid-bit sampling, start/stop validation.
// Optional even-parity frame (8E1) when UART_RX_PARITY_EN is defined; default build is 8N1.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] received_data,
    output logic                  data_is_valid,
    output logic                  rx_error,
    output logic                  o_busy
);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1, rx_s;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  valid_d, error_d;
    logic                  parity_ok;

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d;
    assign parity_ok = !perr_q;
`else
    assign parity_ok = 1'b1;
`endif

    // Output protocol: data_is_valid and rx_error are single-cycle strobes with no
    // backpressure; received_data changes only on the data_is_valid edge and then holds.
    assign o_busy = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1         <= 1'b1;
            rx_s          <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            received_data <= '0;
            data_is_valid <= 1'b0;
            rx_error      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q        <= 1'b0;
`endif
        end else begin
            sync1         <= serial_in;
            rx_s          <= sync1;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            received_data <= data_d;
            data_is_valid <= valid_d;
            rx_error      <= error_d;
`ifdef UART_RX_PARITY_EN
            perr_q        <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = received_data;
        valid_d = 1'b0;
        error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (cnt_q == CNT_HALF) begin
                    if (!rx_s) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    perr_d  = rx_s ^ (^shift_q);
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                        if (parity_ok) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else begin
                        // Low stop bit: framing error or break; wait for the line to recover.
                        error_d = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: vector table of frames plus hand-written sequences
// for reset, glitch, timing, back-to-back frames and mid-frame reset.
module tb_uart_rx;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int VALID_LAT = 2 + CPB / 2 + (8 + 1 + PAR_BITS) * CPB + 1;
    localparam int FRAME_CYC = (8 + 2 + PAR_BITS) * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in;
    logic [7:0] received_data;
    logic       data_is_valid;
    logic       rx_error;
    logic       o_busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .received_data (received_data),
        .data_is_valid (data_is_valid),
        .rx_error      (rx_error),
        .o_busy        (o_busy)
    );

    // Clock and cycle count
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled on the falling edge
    logic [7:0] dv_data_q[$];
    int         dv_cyc_q[$];
    int         err_cyc_q[$];
    int         both_cnt = 0;
    int         busy_rise_cyc = -1;
    int         busy_fall_cyc = -1;
    logic       busy_prev = 1'b0;

    always @(negedge clk) begin
        if (data_is_valid) begin
            dv_data_q.push_back(received_data);
            dv_cyc_q.push_back(cyc);
        end
        if (rx_error) err_cyc_q.push_back(cyc);
        if (data_is_valid && rx_error) both_cnt = both_cnt + 1;
        if (o_busy && !busy_prev) busy_rise_cyc = cyc;
        if (!o_busy && busy_prev) busy_fall_cyc = cyc;
        busy_prev = o_busy;
    end

    // Scoreboard
    logic [7:0] exp_q[$];
    int         dv_rd = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] model_data = 8'h00;
    int         frame_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drain_sb(input string name);
        while (dv_rd < dv_data_q.size()) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s unexpected valid: got %0h, expected none", name, dv_data_q[dv_rd]);
            end else begin
                check({name, " data"}, 32'(dv_data_q[dv_rd]), 32'(exp_q.pop_front()));
            end
            dv_rd++;
        end
        check({name, " pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Drivers
    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        frame_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`else
        if (par_flip) frame_start = frame_start;
`endif
        drive_bit(stop_bit);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       par_flip;
        int         hold_low;
        logic       exp_valid;
        logic       exp_error;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic [7:0] d, input logic sb, input logic pf, input int hl,
                           input logic ev, input logic ee);
        vec_t v;
        v.data = d; v.stop_bit = sb; v.par_flip = pf; v.hold_low = hl;
        v.exp_valid = ev; v.exp_error = ee;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv0, er0;
        add_vec(8'h3C, 1'b1, 1'b0, 0,   1'b1, 1'b0);
        add_vec(8'h81, 1'b0, 1'b0, 100, 1'b0, 1'b1);
        add_vec(8'h55, 1'b1, 1'b0, 0,   1'b1, 1'b0);
        add_vec(8'h7E, 1'b1, 1'b0, 0,   1'b1, 1'b0);
        add_vec(8'h01, 1'b1, 1'b0, 0,   1'b1, 1'b0);
        add_vec(8'h80, 1'b1, 1'b0, 0,   1'b1, 1'b0);
        add_vec(8'hC3, 1'b0, 1'b0, 0,   1'b0, 1'b1);
        add_vec(8'hAA, 1'b1, 1'b0, 0,   1'b1, 1'b0);
`ifdef UART_RX_PARITY_EN
        add_vec(8'h07, 1'b1, 1'b0, 0,   1'b1, 1'b0);
        add_vec(8'h07, 1'b1, 1'b1, 0,   1'b0, 1'b1);
`endif

        // Reset
        serial_in = 1'b1;
        reset     = 1'b1;
        repeat (5) @(negedge clk);
        check("reset received_data", 32'(received_data), 32'h00);
        check("reset data_is_valid", 32'(data_is_valid), 32'h0);
        check("reset rx_error", 32'(rx_error), 32'h0);
        check("reset o_busy", 32'(o_busy), 32'h0);
        reset = 1'b0;

        // Idle line
        repeat (200) @(negedge clk);
        check("idle valid count", dv_cyc_q.size(), 0);
        check("idle error count", err_cyc_q.size(), 0);
        check("idle o_busy", 32'(o_busy), 32'h0);
        check("idle received_data", 32'(received_data), 32'h00);

        // Timed frame 0xA5
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        drain_sb("a5");
        model_data = 8'hA5;
        check("a5 valid count", dv_cyc_q.size(), 1);
        if (dv_cyc_q.size() > 0)
            check("a5 valid latency", dv_cyc_q[0] - frame_start, VALID_LAT);
        check("a5 busy rise", busy_rise_cyc - frame_start, 3);
        check("a5 busy fall", busy_fall_cyc - frame_start, VALID_LAT);
        check("a5 error count", err_cyc_q.size(), 0);
        check("a5 received_data", 32'(received_data), 32'hA5);

        // Short low glitch
        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch valid count", dv_cyc_q.size(), 1);
        check("glitch error count", err_cyc_q.size(), 0);
        check("glitch o_busy", 32'(o_busy), 32'h0);

        // Vector table
        foreach (vecs[k]) begin
            dv0 = dv_cyc_q.size();
            er0 = err_cyc_q.size();
            if (vecs[k].exp_valid) begin
                exp_q.push_back(vecs[k].data);
                model_data = vecs[k].data;
            end
            send_frame(vecs[k].data, vecs[k].stop_bit, vecs[k].par_flip);
            repeat (vecs[k].hold_low) @(negedge clk);
            serial_in = 1'b1;
            repeat (20) @(negedge clk);
            drain_sb($sformatf("vec%0d", k));
            check($sformatf("vec%0d valid pulses", k), dv_cyc_q.size() - dv0, 32'(vecs[k].exp_valid));
            check($sformatf("vec%0d error pulses", k), err_cyc_q.size() - er0, 32'(vecs[k].exp_error));
            check($sformatf("vec%0d received_data", k), 32'(received_data), 32'(model_data));
            check($sformatf("vec%0d o_busy", k), 32'(o_busy), 32'h0);
        end

        // Back-to-back 0x00, 0xFF, then reset during a third frame
        dv0 = dv_cyc_q.size();
        er0 = err_cyc_q.size();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        fork
            begin
                send_frame(8'h00, 1'b1, 1'b0);
                send_frame(8'hFF, 1'b1, 1'b0);
                send_frame(8'hFF, 1'b1, 1'b0);
            end
            begin
                repeat (2 * FRAME_CYC + 60) @(negedge clk);
                reset = 1'b1;
                repeat (3) @(negedge clk);
                check("midreset received_data", 32'(received_data), 32'h00);
                check("midreset o_busy", 32'(o_busy), 32'h0);
                check("midreset data_is_valid", 32'(data_is_valid), 32'h0);
                reset = 1'b0;
            end
        join
        model_data = 8'h00;
        repeat (40) @(negedge clk);
        drain_sb("b2b");
        check("b2b valid pulses", dv_cyc_q.size() - dv0, 2);
        if (dv_cyc_q.size() - dv0 == 2)
            check("b2b spacing", dv_cyc_q[dv0 + 1] - dv_cyc_q[dv0], FRAME_CYC);
        check("b2b error pulses", err_cyc_q.size() - er0, 0);
        check("post-reset received_data", 32'(received_data), 32'(model_data));
        check("post-reset o_busy", 32'(o_busy), 32'h0);
        check("valid and error together", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
